// File: rtl/lfsr_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lfsr_gen : parametrised Fibonacci LFSR with seed loading, lockup protection,
//            a registered period-return pulse and a hardware period checker.
//
// Parameters
//   W          : LFSR width in bits (3..24)
//   TAPS       : W-bit feedback mask, bit i set = state[i] feeds back
//   RESET_SEED : non-zero state used at reset and in place of a zero SEED
//
// Ports
//   CLK         in   rising-edge clock
//   RESET       in   asynchronous active-low reset
//   LFSR_EN     in   advance the LFSR one step this cycle
//   LOAD        in   load SEED this cycle (wins over LFSR_EN)
//   SEED        in   W-bit seed value used by LOAD
//   CLR_ERR     in   synchronous clear of LFSR_ERR (a coinciding set wins)
//   LFSR_STATE  out  current state register
//   LFSR_BIT    out  serial output, LFSR_STATE[W-1]
//   LFSR_PERIOD out  one-cycle pulse: state has just returned to the reference
//   LFSR_ERR    out  sticky: observed period differs from 2^W-1
// -----------------------------------------------------------------------------
module lfsr_gen #(
  parameter int          W          = 8,
  parameter logic [W-1:0] TAPS       = W'('hB8),
  parameter logic [W-1:0] RESET_SEED = W'(1)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         LFSR_EN,
  input  logic         LOAD,
  input  logic [W-1:0] SEED,
  input  logic         CLR_ERR,
  output logic [W-1:0] LFSR_STATE,
  output logic         LFSR_BIT,
  output logic         LFSR_PERIOD,
  output logic         LFSR_ERR
);

  // A zero reset seed would lock the register up; fall back to 1 in that case.
  localparam logic [W-1:0] SEED_SAFE = (RESET_SEED == '0) ? W'(1) : RESET_SEED;

  // CNT+1 == 2^W-1 is the same as CNT == 2^W-2 (all ones except the LSB).
  localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] state_q, state_d;
  logic [W-1:0] ref_q,   ref_d;
  logic [W-1:0] cnt_q,   cnt_d;
  logic         period_q, period_d;
  logic         err_q,    err_d;
  logic         err_set;

  logic [W-1:0] fb_terms;
  logic         fb;
  logic [W-1:0] nxt;
  logic [W-1:0] load_val;

  // Feedback taps: each term is a state bit gated by its mask bit.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_fb
      assign fb_terms[gi] = TAPS[gi] & state_q[gi];
    end
  endgenerate

  assign fb       = ^fb_terms;
  assign nxt      = {state_q[W-2:0], fb};
  assign load_val = (SEED == '0) ? SEED_SAFE : SEED;

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = 1'b0;
    err_set  = 1'b0;

    if (LOAD) begin
      // Loading also re-arms the period checker from the new reference.
      state_d = load_val;
      ref_d   = load_val;
      cnt_d   = '0;
    end else if (LFSR_EN) begin
      state_d  = nxt;
      period_d = (nxt == ref_q);
      if (nxt == ref_q) begin
        cnt_d   = '0;
        err_set = (cnt_q != CNT_LAST);  // returned early: short cycle
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        err_set = 1'b1;                 // full period elapsed without return
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Set-dominant sticky flag.
    err_d = err_set | (err_q & ~CLR_ERR);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= SEED_SAFE;
      ref_q    <= SEED_SAFE;
      cnt_q    <= '0;
      period_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      err_q    <= err_d;
    end
  end

  assign LFSR_STATE  = state_q;
  assign LFSR_BIT    = state_q[W-1];
  assign LFSR_PERIOD = period_q;
  assign LFSR_ERR    = err_q;

endmodule

// File: tb/tb_lfsr_gen.sv
`timescale 1ns/1ps
// Bench for lfsr_gen: three instances (default maximal taps, short-cycle taps
// 8'h80, and a 4-bit maximal LFSR) sharing one clock and one reset.
module tb_lfsr_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic       a_en = 0, a_load = 0, a_clr = 0;
  logic [7:0] a_seed = 0;
  logic [7:0] a_state;
  logic       a_bit, a_per, a_err;
  // Instance B: TAPS=8'h80 (period 8)
  logic       b_en = 0, b_load = 0, b_clr = 0;
  logic [7:0] b_seed = 0;
  logic [7:0] b_state;
  logic       b_bit, b_per, b_err;
  // Instance C: W=4, TAPS=4'hC
  logic       c_en = 0, c_load = 0, c_clr = 0;
  logic [3:0] c_seed = 0;
  logic [3:0] c_state;
  logic       c_bit, c_per, c_err;

  lfsr_gen u_a (
    .CLK(clk), .RESET(rst_n), .LFSR_EN(a_en), .LOAD(a_load), .SEED(a_seed),
    .CLR_ERR(a_clr), .LFSR_STATE(a_state), .LFSR_BIT(a_bit),
    .LFSR_PERIOD(a_per), .LFSR_ERR(a_err)
  );

  lfsr_gen #(.W(8), .TAPS(8'h80), .RESET_SEED(8'h01)) u_b (
    .CLK(clk), .RESET(rst_n), .LFSR_EN(b_en), .LOAD(b_load), .SEED(b_seed),
    .CLR_ERR(b_clr), .LFSR_STATE(b_state), .LFSR_BIT(b_bit),
    .LFSR_PERIOD(b_per), .LFSR_ERR(b_err)
  );

  lfsr_gen #(.W(4), .TAPS(4'hC), .RESET_SEED(4'h1)) u_c (
    .CLK(clk), .RESET(rst_n), .LFSR_EN(c_en), .LOAD(c_load), .SEED(c_seed),
    .CLR_ERR(c_clr), .LFSR_STATE(c_state), .LFSR_BIT(c_bit),
    .LFSR_PERIOD(c_per), .LFSR_ERR(c_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [23:0] nxt_model(input logic [23:0] s, input logic [23:0] taps, input int w);
    logic fb;
    fb = ^(s & taps);
    return ((s << 1) | {23'd0, fb}) & ((24'd1 << w) - 24'd1);
  endfunction

  typedef struct {
    logic       load;
    logic       en;
    logic [7:0] seed;
    logic       clr;
    logic [7:0] exp_state;
    logic       exp_per;
    logic       exp_err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m;
    logic [3:0] mc;
    logic       seen [256];
    int         uniq;
    int         pulses;

    // load, en, seed, clr, exp_state, exp_per, exp_err
    vecs[0]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h04, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0}; // zero seed, EN ignored
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0}; // hold
    vecs[7]  = '{1'b1, 1'b0, 8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'hB4, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hB4, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0};

    // ---- reset state ----
    do_reset();
    check("rst_state", a_state, 8'h01);
    check("rst_bit",   a_bit,   1'b0);
    check("rst_per",   a_per,   1'b0);
    check("rst_err",   a_err,   1'b0);

    // ---- table-driven vectors on instance A ----
    for (int i = 0; i < 12; i++) begin
      a_load = vecs[i].load; a_en = vecs[i].en; a_seed = vecs[i].seed; a_clr = vecs[i].clr;
      step();
      $display("vec %0d: load=%0b en=%0b seed=%02h -> state=%02h per=%0b err=%0b",
               i, vecs[i].load, vecs[i].en, vecs[i].seed, a_state, a_per, a_err);
      check($sformatf("vec%0d_state", i), a_state, vecs[i].exp_state);
      check($sformatf("vec%0d_bit", i),   a_bit,   vecs[i].exp_state[7]);
      check($sformatf("vec%0d_per", i),   a_per,   vecs[i].exp_per);
      check($sformatf("vec%0d_err", i),   a_err,   vecs[i].exp_err);
    end
    a_load = 0; a_en = 0; a_clr = 0; a_seed = 0;

    // ---- 600 continuous advances from reset ----
    do_reset();
    m = 8'h01;
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    uniq = 0;
    pulses = 0;
    a_en = 1;
    for (int i = 1; i <= 600; i++) begin
      step();
      m = nxt_model({16'd0, m}, 24'hB8, 8)[7:0];
      check($sformatf("run600_state@%0d", i), a_state, m);
      check($sformatf("run600_per@%0d", i), a_per, (i % 255) == 0);
      check($sformatf("run600_err@%0d", i), a_err, 1'b0);
      if (a_per) pulses++;
      if (i <= 255) begin
        if (!seen[a_state]) uniq++;
        seen[a_state] = 1'b1;
      end
    end
    $display("run600: pulses=%0d unique_states=%0d", pulses, uniq);
    check("run600_unique", uniq, 255);
    check("run600_zero_seen", seen[0], 1'b0);
    check("run600_pulses", pulses, 2);
    a_en = 0;

    // ---- LOAD 0x5A then one period ----
    a_load = 1; a_seed = 8'h5A;
    step();
    a_load = 0; a_en = 1;
    pulses = 0;
    for (int i = 1; i <= 255; i++) begin
      step();
      if (a_per) pulses++;
      if (i == 255) begin
        check("seed5a_per", a_per, 1'b1);
        check("seed5a_state", a_state, 8'h5A);
      end
    end
    $display("seed5a: pulses=%0d", pulses);
    check("seed5a_pulses", pulses, 1);
    a_en = 0;

    // ---- stall mid-period ----
    a_load = 1; a_seed = 8'h01;
    step();
    a_load = 0; a_en = 1;
    repeat (100) step();
    a_en = 0;
    pulses = 0;
    for (int i = 0; i < 37; i++) begin
      step();
      if (a_per) pulses++;
    end
    check("stall_no_pulse", pulses, 0);
    a_en = 1;
    for (int i = 1; i <= 155; i++) begin
      step();
      if (a_per) pulses++;
      if (i == 154) check("stall_per_before", a_per, 1'b0);
    end
    $display("stall: pulse after resume=%0b state=%02h err=%0b", a_per, a_state, a_err);
    check("stall_per", a_per, 1'b1);
    check("stall_state", a_state, 8'h01);
    check("stall_pulses", pulses, 1);
    check("stall_err", a_err, 1'b0);
    a_en = 0;

    // ---- bad taps on instance B ----
    do_reset();
    b_en = 1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) begin
        check("bad_per7", b_per, 1'b0);
        check("bad_err7", b_err, 1'b0);
      end
    end
    $display("badtaps: adv8 state=%02h per=%0b err=%0b", b_state, b_per, b_err);
    check("bad_per8", b_per, 1'b1);
    check("bad_err8", b_err, 1'b1);
    check("bad_state8", b_state, 8'h01);
    b_en = 0; b_clr = 1;
    step();
    check("bad_clr", b_err, 1'b0);
    b_clr = 0; b_en = 1;
    repeat (7) step();
    check("bad_err_2nd7", b_err, 1'b0);
    b_clr = 1;
    step();
    $display("badtaps: set+clr state=%02h per=%0b err=%0b", b_state, b_per, b_err);
    check("bad_setdom_per", b_per, 1'b1);
    check("bad_setdom_err", b_err, 1'b1);
    b_clr = 0; b_en = 0;
    step();
    check("bad_sticky", b_err, 1'b1);

    // ---- async reset mid-run ----
    a_load = 1; a_seed = 8'h01;
    step();
    a_load = 0; a_en = 1;
    m = 8'h01;
    for (int i = 0; i < 40; i++) begin
      step();
      m = nxt_model({16'd0, m}, 24'hB8, 8)[7:0];
    end
    check("arst_pre_state", a_state, m);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: a_state=%02h a_per=%0b b_err=%0b", a_state, a_per, b_err);
    check("arst_state", a_state, 8'h01);
    check("arst_bit",   a_bit,   1'b0);
    check("arst_per",   a_per,   1'b0);
    check("arst_b_err", b_err,   1'b0);
    check("arst_b_state", b_state, 8'h01);
    a_en = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---- W=4, TAPS=4'hC ----
    check("w4_rst_state", c_state, 4'h1);
    mc = 4'h1;
    pulses = 0;
    c_en = 1;
    for (int i = 1; i <= 45; i++) begin
      step();
      mc = nxt_model({20'd0, mc}, 24'hC, 4)[3:0];
      check($sformatf("w4_state@%0d", i), c_state, mc);
      check($sformatf("w4_per@%0d", i), c_per, (i % 15) == 0);
      if (c_per) pulses++;
    end
    $display("w4: pulses=%0d err=%0b", pulses, c_err);
    check("w4_pulses", pulses, 3);
    check("w4_err", c_err, 1'b0);
    c_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR. Successor to the fixed 8-bit LFSR that feeds the SISO data input and the byte output.
- Adds configurable width and taps, seed loading with lockup protection, and a registered period-return pulse.
- Adds a hardware period checker that flags non-maximal tap sets.
- Clocked from the selected clock (CLK_OUT) and reset by the resynchronised INT_RESET in the top level.

Parameters:
W, 8, LFSR width in bits; legal range 3..24
TAPS, 8'hB8, W-bit feedback mask; bit i set = state[i] feeds back
RESET_SEED, 1, W-bit non-zero state loaded at reset and substituted for a zero seed

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous active-low reset
LFSR_EN  input  1  advance the LFSR one step this cycle
LOAD  input  1  load SEED this cycle (priority over LFSR_EN)
SEED  input  W  seed value for LOAD
CLR_ERR  input  1  synchronous clear of LFSR_ERR
LFSR_STATE  output  W  current state register
LFSR_BIT  output  1  serial output = LFSR_STATE[W-1]
LFSR_PERIOD  output  1  one-cycle pulse: state has just returned to the reference value
LFSR_ERR  output  1  sticky: observed period differs from 2^W-1

Behaviour:
- Reset (RESET=0, asynchronous):
  - STATE=RESET_SEED, REF=RESET_SEED, CNT=0.
  - LFSR_PERIOD=0, LFSR_ERR=0. LFSR_BIT follows STATE[W-1].
- Feedback: fb = XOR-reduce(STATE & TAPS). Advance: STATE <= {STATE[W-2:0], fb}.
- Internal registers:
  - REF (W bits): reference state.
  - CNT (W bits): advances since STATE last left REF.
- Priority per rising edge: LOAD > LFSR_EN > hold.
- LOAD=1:
  - STATE <= (SEED==0) ? RESET_SEED : SEED. REF gets the same value.
  - CNT <= 0, LFSR_PERIOD <= 0. LFSR_ERR unchanged.
  - LFSR_EN is ignored that cycle. A zero state is therefore unreachable: no lockup.
- LFSR_EN=1, LOAD=0:
  - Compute nxt (the advanced state). STATE <= nxt. LFSR_PERIOD <= (nxt==REF).
  - If nxt==REF: CNT <= 0. If CNT+1 != 2^W-1, set error.
  - Else if CNT+1 == 2^W-1: set error (full period elapsed without return), CNT <= 0.
  - Else CNT <= CNT+1.
- LFSR_EN=0, LOAD=0: STATE, REF and CNT hold; LFSR_PERIOD <= 0.
- Latency:
  - LFSR_PERIOD is registered; it is high in exactly the cycle in which LFSR_STATE==REF following an advance.
  - Never high after reset or LOAD alone.
- LFSR_ERR:
  - Set-dominant: when the set condition and CLR_ERR coincide, it ends at 1.
  - Otherwise CLR_ERR=1 clears it next edge.
- Consecutive periods with continuous LFSR_EN: LFSR_PERIOD pulses every 2^W-1 cycles with a maximal TAPS.
- Stall behaviour: holding LFSR_EN low mid-period does not disturb CNT or the pulse position in advance count.
- Reset mid-operation: all registers return to reset values immediately (async). Release is handled by the top-level resynchroniser.
- All outputs are direct register outputs or LFSR_BIT = wire of STATE MSB. No combinational path from inputs to outputs.

Test Plan:
- Reset, W=8 defaults:
  - Expect LFSR_STATE=0x01, LFSR_BIT=0, LFSR_PERIOD=0, LFSR_ERR=0.
  - Then LFSR_EN=1 for 5 cycles -> states 0x02,0x04,0x08,0x11,0x23.
- Defaults, LFSR_EN held 1 for 600 cycles:
  - LFSR_PERIOD pulses exactly at advances 255 and 510, with LFSR_STATE=0x01 at each; LFSR_ERR stays 0.
  - All 255 non-zero states are visited once per period.
- Zero seed: LOAD=1 with SEED=0x00 and LFSR_EN=1 simultaneously:
  - Next cycle LFSR_STATE=0x01 (no advance), LFSR_PERIOD=0.
  - LOAD SEED=0x5A, then 255 advances -> single PERIOD pulse with STATE=0x5A.
- Stall: advance 100 steps, drop LFSR_EN for 37 cycles, resume:
  - PERIOD pulse occurs after 155 further advances; LFSR_ERR=0.
- Bad taps (TAPS=8'h80, period 8):
  - LFSR_PERIOD at advance 8 and LFSR_ERR=1 on the same edge.
  - CLR_ERR=1 alone clears it; CLR_ERR coinciding with the next error event leaves LFSR_ERR=1.
- Async reset mid-run at a non-clock instant after 40 advances:
  - Outputs immediately return to reset values. Re-run with W=4, TAPS=4'hC gives PERIOD every 15 advances, ERR=0.
